// File: rtl/fetch_controller_if.sv
// Fetch-side bus of the fetch controller: the instruction memory port, the control inputs
// and the presented instruction stream.
interface fetch_controller_if;
    logic [31:0] pc;
    logic [31:0] code_mem_rd;
    logic        halt;
    logic        br_valid;
    logic [31:0] br_target;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        pc_fault;

    modport master (
        output pc,
        input  code_mem_rd,
        input  halt,
        input  br_valid,
        input  br_target,
        input  out_ready,
        output instr,
        output instr_pc,
        output instr_valid,
        output pc_fault
    );

    modport slave (
        input  pc,
        output code_mem_rd,
        output halt,
        output br_valid,
        output br_target,
        input  out_ready,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        input  pc_fault
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller for a synchronous code memory, with a one-entry skid buffer
// that absorbs downstream stalls. Redirect and halt handling are included.
module fetch_controller #(
    parameter int unsigned CODE_WORDS = 512,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              resetn,
    fetch_controller_if.master bus
);

    localparam logic [31:0] CODE_BYTES = 32'(CODE_WORDS) * 32'd4;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e      state_r;
    logic [31:0] pc_r;
    logic [31:0] req_pc_r;
    logic        req_valid_r;
    logic        skid_full_r;
    logic [31:0] skid_instr_r;
    logic [31:0] skid_pc_r;
    logic        pc_fault_r;
    logic        instr_valid_s;
    logic        blocked_s;

    // Next sequential fetch address; anything past the end of code memory wraps to 0.
    function automatic logic [31:0] inc_pc(input logic [31:0] p);
        logic [31:0] n;
        n = p + 32'd4;
        if (n >= CODE_BYTES) begin
            inc_pc = 32'd0;
        end else begin
            inc_pc = n;
        end
    endfunction

    // Present the skid entry while it is full, otherwise the read data returning this cycle.
    always_comb begin
        if (skid_full_r) begin
            bus.instr     = skid_instr_r;
            bus.instr_pc  = skid_pc_r;
            instr_valid_s = 1'b1;
        end else begin
            bus.instr     = bus.code_mem_rd;
            bus.instr_pc  = req_pc_r;
            instr_valid_s = req_valid_r;
        end
    end

    assign bus.instr_valid = instr_valid_s;
    assign blocked_s       = instr_valid_s & ~bus.out_ready;
    assign bus.pc          = pc_r;
    assign bus.pc_fault    = pc_fault_r;

    // Fetch state machine: pc sequencing, skid capture/release, redirect and halt.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_RUN;
            pc_r         <= RESET_PC;
            req_pc_r     <= RESET_PC;
            req_valid_r  <= 1'b0;
            skid_full_r  <= 1'b0;
            skid_instr_r <= 32'd0;
            skid_pc_r    <= 32'd0;
            pc_fault_r   <= 1'b0;
        end else begin
            req_pc_r <= pc_r;
            if (bus.br_valid) begin
                if (bus.br_target >= CODE_BYTES) begin
                    pc_r       <= 32'd0;
                    pc_fault_r <= 1'b1;
                end else begin
                    pc_r <= {bus.br_target[31:2], 2'b00};
                end
                req_valid_r <= 1'b0;
                skid_full_r <= 1'b0;
                state_r     <= bus.halt ? ST_HALT : ST_RUN;
            end else begin
                case (state_r)
                    ST_RUN: begin
                        if (blocked_s) begin
                            // pc is held, so next cycle's read refetches the successor.
                            skid_instr_r <= bus.code_mem_rd;
                            skid_pc_r    <= req_pc_r;
                            skid_full_r  <= 1'b1;
                            req_valid_r  <= ~bus.halt;
                            state_r      <= ST_HOLD;
                        end else if (bus.halt) begin
                            req_valid_r <= 1'b0;
                            state_r     <= ST_HALT;
                        end else begin
                            pc_r        <= inc_pc(pc_r);
                            req_valid_r <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (!bus.out_ready) begin
                            if (bus.halt) begin
                                req_valid_r <= 1'b0;
                            end else begin
                                req_valid_r <= req_valid_r;
                            end
                        end else if (bus.halt) begin
                            skid_full_r <= 1'b0;
                            req_valid_r <= 1'b0;
                            state_r     <= ST_HALT;
                        end else begin
                            // req_pc equals pc here, so the released read is always valid.
                            skid_full_r <= 1'b0;
                            pc_r        <= inc_pc(pc_r);
                            req_valid_r <= 1'b1;
                            state_r     <= ST_RUN;
                        end
                    end
                    ST_HALT: begin
                        if (bus.halt) begin
                            req_valid_r <= 1'b0;
                        end else begin
                            pc_r        <= inc_pc(pc_r);
                            req_valid_r <= 1'b1;
                            state_r     <= ST_RUN;
                        end
                    end
                    default: begin
                        req_valid_r <= 1'b0;
                        skid_full_r <= 1'b0;
                        state_r     <= ST_RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: code memory holds mem[i]=i, so every presented
// instruction must equal its byte address divided by four.
module tb_fetch_controller;

    logic clk;
    logic resetn;
    int   checks_cnt;
    int   errors_cnt;

    fetch_controller_if bus();

    fetch_controller #(
        .CODE_WORDS(512),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous code memory model with mem[i] = i.
    always_ff @(posedge clk) begin
        bus.code_mem_rd <= bus.pc >> 2;
    end

    task automatic check_val(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
        checks_cnt++;
        if (observed !== expected) begin
            errors_cnt++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] exp_pc);
        check_val({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd1);
        check_val({tag, "_pc"}, bus.instr_pc, exp_pc);
        check_val({tag, "_instr"}, bus.instr, exp_pc >> 2);
    endtask

    task automatic expect_bubble(input string tag);
        check_val({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        checks_cnt    = 0;
        errors_cnt    = 0;
        resetn        = 1'b0;
        bus.halt      = 1'b0;
        bus.br_valid  = 1'b0;
        bus.br_target = 32'd0;
        bus.out_ready = 1'b1;

        tick();
        expect_bubble("rst");
        check_val("rst_pc", bus.pc, 32'h0);
        check_val("rst_fault", {31'd0, bus.pc_fault}, 32'd0);
        resetn = 1'b1;

        // Stream from reset: 0, 4, then 8 gets backpressured for three cycles.
        tick(); expect_instr("s0", 32'h0);
        tick(); expect_instr("s4", 32'h4);
        tick(); expect_instr("s8", 32'h8);
        bus.out_ready = 1'b0;
        tick(); expect_instr("bp1", 32'h8);
        tick(); expect_instr("bp2", 32'h8);
        tick(); expect_instr("bp3", 32'h8);
        bus.out_ready = 1'b1;
        tick(); expect_instr("bp12", 32'hC);
        tick(); expect_instr("bp16", 32'h10);

        // Redirect to 0x103 while 16 is presented.
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h103;
        tick(); expect_bubble("br_bub");
        bus.br_valid  = 1'b0;
        tick(); expect_instr("br100", 32'h100);
        tick(); expect_instr("br104", 32'h104);

        // Redirect with a full skid: 0x104 must be dropped.
        bus.out_ready = 1'b0;
        tick(); expect_instr("sk104", 32'h104);
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h200;
        tick(); expect_bubble("sk_bub");
        bus.br_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick(); expect_instr("sk200", 32'h200);
        tick(); expect_instr("sk204", 32'h204);

        // Halt while pc 20 is presented and stalled.
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h14;
        tick(); expect_bubble("h_bub");
        bus.br_valid  = 1'b0;
        tick(); expect_instr("h20", 32'h14);
        bus.halt      = 1'b1;
        bus.out_ready = 1'b0;
        tick(); expect_instr("h20a", 32'h14);
        tick(); expect_instr("h20b", 32'h14);
        bus.out_ready = 1'b1;
        tick(); expect_bubble("halt1");
        tick(); expect_bubble("halt2");
        check_val("halt_pc", bus.pc, 32'h18);
        bus.halt = 1'b0;
        tick(); expect_instr("r24", 32'h18);
        tick(); expect_instr("r28", 32'h1C);

        // Wrap at the end of code memory.
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h7F8;
        tick(); expect_bubble("w_bub");
        bus.br_valid  = 1'b0;
        tick(); expect_instr("w7f8", 32'h7F8);
        tick(); expect_instr("w7fc", 32'h7FC);
        tick(); expect_instr("w0", 32'h0);
        tick(); expect_instr("w4", 32'h4);
        check_val("w_fault", {31'd0, bus.pc_fault}, 32'd0);

        // Out-of-range redirect sets the sticky fault and restarts at 0.
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h800;
        tick(); expect_bubble("f_bub");
        check_val("f_pc", bus.pc, 32'h0);
        check_val("f_fault", {31'd0, bus.pc_fault}, 32'd1);
        bus.br_valid  = 1'b0;
        tick(); expect_instr("f0", 32'h0);
        tick(); expect_instr("f4", 32'h4);
        check_val("f_sticky", {31'd0, bus.pc_fault}, 32'd1);

        // Async reset in the middle of a stall.
        bus.out_ready = 1'b0;
        tick(); expect_instr("ar_hold", 32'h4);
        #2;
        resetn = 1'b0;
        #1;
        expect_bubble("ar_now");
        check_val("ar_pc", bus.pc, 32'h0);
        check_val("ar_fault", {31'd0, bus.pc_fault}, 32'd0);
        tick();
        expect_bubble("ar_low");
        resetn        = 1'b1;
        bus.out_ready = 1'b1;
        tick(); expect_instr("ar0", 32'h0);
        tick(); expect_instr("ar4", 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter CODE_WORDS, default 512, giving the instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port resetn  input  1  is the reset: asynchronous, active-low.
REQ-005 Port pc  output  32  is the fetch address driven to the synchronous instruction memory (read data returns one cycle later).
REQ-006 Port code_mem_rd  input  32  is the instruction memory read data, equal to mem[pc sampled at the previous edge].
REQ-007 Port halt  input  1  requests that fetching stop.
REQ-008 Port br_valid  input  1  is the redirect request from a later stage.
REQ-009 Port br_target  input  32  is the redirect byte address.
REQ-010 Port out_ready  input  1  indicates downstream accepts the presented instruction.
REQ-011 Port instr  output  32  is the presented instruction.
REQ-012 Port instr_pc  output  32  is the address of instr.
REQ-013 Port instr_valid  output  1  qualifies instr and instr_pc.
REQ-014 Port pc_fault  output  1  is a sticky flag for an out-of-range redirect.

Function
REQ-015 Internal state SHALL be: pc, req_pc (address of the in-flight read), req_valid, a one-entry skid buffer (skid_full, skid_instr, skid_pc), pc_fault, and a state register with states RUN, HOLD and HALT.
REQ-016 Outputs SHALL be combinational from state: skid_full=1 gives instr=skid_instr, instr_pc=skid_pc, instr_valid=1; otherwise instr=code_mem_rd, instr_pc=req_pc, instr_valid=req_valid.
REQ-017 A transfer SHALL occur in any cycle where instr_valid and out_ready are both 1; blocked = instr_valid & ~out_ready.
REQ-018 Every edge SHALL load req_pc <= pc, whatever the state.
REQ-019 In RUN with blocked=0: pc <= pc+4 and req_valid <= 1.
REQ-020 In RUN with blocked=1 (skid empty): skid <= {code_mem_rd, req_pc}; skid_full <= 1; pc held; req_valid <= 1 (refetch of the held pc); next state HOLD.
REQ-021 In HOLD with out_ready=0: skid, pc and req_valid SHALL be held.
REQ-022 In HOLD with out_ready=1: skid_full <= 0; pc <= pc+4; next state RUN. The next instruction comes from code_mem_rd with no bubble.
REQ-023 Increment wrap: if pc+4 == CODE_WORDS*4, pc SHALL become 0.
REQ-024 br_valid=1 SHALL have priority over every other input, and in any state it SHALL do all of the following:
- pc <= {br_target[31:2],2'b00};
- req_valid <= 0;
- skid_full <= 0;
- next state RUN, or HALT if halt=1.
REQ-025 The current-cycle output and its handshake SHALL still complete during a redirect cycle.
REQ-026 A redirect with br_target >= CODE_WORDS*4 SHALL load pc <= 0 and set pc_fault=1; pc_fault SHALL clear only on reset.
REQ-027 halt=1 without br_valid SHALL do the following:
- hold pc;
- req_valid <= 0;
- enter HALT once any skid contents transfer; a full skid SHALL be kept and presented until accepted.
REQ-028 In HALT, instr_valid SHALL be 0 and pc SHALL be held.
REQ-029 Leaving HALT: when halt=0, req_valid <= 1 and the state SHALL return to RUN; the first valid instruction is mem[pc] one cycle later.
REQ-030 No instruction SHALL be duplicated or dropped across any sequence of stall, halt or wrap.
REQ-031 Only redirect SHALL discard instructions, namely the in-flight read and the skid.

Reset
REQ-032 resetn=0 SHALL immediately force:
- pc=RESET_PC, req_pc=RESET_PC;
- req_valid=0, skid_full=0, pc_fault=0;
- state RUN;
- therefore instr_valid=0.
REQ-033 The first edge after resetn rises SHALL issue the fetch of RESET_PC. instr_valid SHALL first be 1, with instr_pc=RESET_PC, in the following cycle.
REQ-034 Reset asserted mid-stall or mid-redirect SHALL discard all state with no residual valid.

Verification
REQ-035 Stream: reset release, out_ready=1, mem[i]=i -> instr_pc 0,4,8,... each cycle, instr 0,1,2,..., no gaps.
REQ-036 Backpressure: out_ready=0 for 3 cycles while presenting pc 8 -> instr 2 stays presented. When out_ready returns, the output sequence SHALL be 8 (instr 2), 12, 16 on consecutive cycles.
REQ-037 Redirect: br_valid=1, br_target=32'h103 while presenting pc 16 -> one bubble cycle (instr_valid=0), then instr_pc=32'h100, then 32'h104. Same test with a full skid -> skid contents dropped.
REQ-038 Wrap and fault:
- CODE_WORDS=512, stream through pc 32'h7FC -> next instr_pc=0;
- br_target=32'h800 -> pc=0 and pc_fault=1, persisting until reset.
REQ-039 Halt: halt=1 at pc 20 with out_ready=0 -> pc 20 still delivered when out_ready rises, then instr_valid=0. Drop halt -> stream resumes at the held pc with no skipped address.
REQ-040 Async reset: assert resetn=0 mid-cycle during HOLD -> instr_valid=0 and pc=RESET_PC with no clock edge; normal restart per REQ-033.
